// File: rtl/sa_jtag_pkg.sv
// sa_jtag_pkg: shared helpers and strobe encoding for the segmented JTAG data register
package sa_jtag_pkg;
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_CAP  = 2'd1;
  localparam logic [1:0] OP_SHF  = 2'd2;
  localparam logic [1:0] OP_UPD  = 2'd3;

  function automatic int clog2(int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction

  // An enabled segment contributes its full width; a disabled one only its bypass flop.
  function automatic int chain_len_f(logic [31:0] mask, int seg_w, int num_seg);
    int l;
    l = 0;
    for (int s = 0; s < num_seg; s++) l += mask[s] ? seg_w : 1;
    return l;
  endfunction
endpackage

// File: rtl/sa_jtag_dr_seg.sv
// sa_jtag_dr_seg: one DR segment (shift slice, bypass flop, latched enable, shadow slice)
//   op_i      sel-qualified strobe (OP_NONE/CAP/SHF/UPD)
//   upd_ok_i  update accepted this cycle
//   seg_en_i  enable bit, latched on capture
//   d_i       capture data slice
//   si_i/so_o serial in/out of this segment
//   q_o       shadow slice; en_o latched enable
module sa_jtag_dr_seg import sa_jtag_pkg::*; #(
  parameter int SEG_W = 4,
  parameter logic [SEG_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [1:0]       op_i,
  input  logic             upd_ok_i,
  input  logic             seg_en_i,
  input  logic [SEG_W-1:0] d_i,
  input  logic             si_i,
  output logic             so_o,
  output logic [SEG_W-1:0] q_o,
  output logic             en_o
);
  logic [SEG_W-1:0] sr_q, sr_d, sr_sh, q_q, q_d;
  logic bp_q, bp_d, en_q, en_d;
  always_comb begin
    sr_sh = sr_q >> 1;
    sr_sh[SEG_W-1] = si_i;
    sr_d = op_i == OP_CAP ? d_i : (op_i == OP_SHF && en_q) ? sr_sh : sr_q;
    bp_d = op_i == OP_CAP ? 1'b0 : (op_i == OP_SHF && !en_q) ? si_i : bp_q;
    en_d = op_i == OP_CAP ? seg_en_i : en_q;
    q_d  = (op_i == OP_UPD && upd_ok_i && en_q) ? sr_q : q_q;
  end
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      sr_q <= RESET_VAL;
      bp_q <= 1'b0;
      en_q <= 1'b1;
      q_q  <= RESET_VAL;
    end else begin
      sr_q <= sr_d;
      bp_q <= bp_d;
      en_q <= en_d;
      q_q  <= q_d;
    end
  assign so_o = en_q ? sr_q[0] : bp_q;
  assign q_o  = q_q;
  assign en_o = en_q;
endmodule

// File: rtl/sa_jtag_seg_dr.sv
// sa_jtag_seg_dr: segmented JTAG DR with per-segment bypass and shadow update stage
//   sel, capture_dr, shift_dr, update_dr  TAP controls (capture > shift > update)
//   seg_en  segment mask, sampled on capture; D parallel capture data
//   scanin/scanout  serial chain; Q shadow output
//   chain_len  chain length for the latched mask; upd_err rejected-update pulse
//   SA_JTAG_LEN_CHECK_EN: accept update only when shift count equals chain_len
module sa_jtag_seg_dr import sa_jtag_pkg::*; #(
  parameter int JTAG_REG_WIDTH = 16,
  parameter int NUM_SEG = 4,
  parameter logic [JTAG_REG_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                clk,
  input  logic                                reset_,
  input  logic                                sel,
  input  logic                                capture_dr,
  input  logic                                shift_dr,
  input  logic                                update_dr,
  input  logic [NUM_SEG-1:0]                  seg_en,
  input  logic [JTAG_REG_WIDTH-1:0]           D,
  input  logic                                scanin,
  output logic                                scanout,
  output logic [JTAG_REG_WIDTH-1:0]           Q,
  output logic [clog2(JTAG_REG_WIDTH+1)-1:0]  chain_len,
  output logic                                upd_err
);
  localparam int SEG_W = JTAG_REG_WIDTH / NUM_SEG;
  localparam int CW = clog2(JTAG_REG_WIDTH + 1);
  logic [1:0] op;
  logic [NUM_SEG:0] ch;
  logic [NUM_SEG-1:0] en_q;
  logic upd_ok;
  assign op = !sel ? OP_NONE : capture_dr ? OP_CAP : shift_dr ? OP_SHF : update_dr ? OP_UPD : OP_NONE;
  assign ch[NUM_SEG] = scanin;
  genvar s;
  for (s = 0; s < NUM_SEG; s++) begin : g_seg
    sa_jtag_dr_seg #(.SEG_W(SEG_W), .RESET_VAL(RESET_VALUE[s*SEG_W +: SEG_W])) u_seg (
      .clk(clk),
      .reset_(reset_),
      .op_i(op),
      .upd_ok_i(upd_ok),
      .seg_en_i(seg_en[s]),
      .d_i(D[s*SEG_W +: SEG_W]),
      .si_i(ch[s+1]),
      .so_o(ch[s]),
      .q_o(Q[s*SEG_W +: SEG_W]),
      .en_o(en_q[s])
    );
  end
  assign scanout = sel & ch[0];
  assign chain_len = CW'(chain_len_f(32'(en_q), SEG_W, NUM_SEG));
`ifdef SA_JTAG_LEN_CHECK_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  always_comb begin
    cnt_d = op == OP_CAP ? '0 : (op == OP_SHF && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    err_d = op == OP_UPD && !upd_ok;
  end
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign upd_ok  = cnt_q == chain_len;
  assign upd_err = err_q;
`else
  assign upd_ok  = 1'b1;
  assign upd_err = 1'b0;
`endif
endmodule

// File: tb/tb_sa_jtag_seg_dr.sv
// tb_sa_jtag_seg_dr: directed self-checking bench for sa_jtag_seg_dr
module tb_sa_jtag_seg_dr;
`ifdef SA_JTAG_LEN_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif
  logic clk = 0, reset_ = 0, sel = 0, capture_dr = 0, shift_dr = 0, update_dr = 0, scanin = 0;
  logic [3:0] seg_en = '1;
  logic [15:0] D = '0;
  logic scanout, upd_err;
  logic [15:0] Q, so;
  logic [4:0] chain_len;
  int total = 0, bad = 0;

  sa_jtag_seg_dr #(.JTAG_REG_WIDTH(16), .NUM_SEG(4), .RESET_VALUE(16'hA5A5)) dut (
    .clk(clk), .reset_(reset_), .sel(sel), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .seg_en(seg_en), .D(D), .scanin(scanin), .scanout(scanout),
    .Q(Q), .chain_len(chain_len), .upd_err(upd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [15:0] d, input logic [3:0] m);
    D = d;
    seg_en = m;
    capture_dr = 1;
    cyc();
    capture_dr = 0;
  endtask

  task automatic shift(input logic [15:0] din, input int n, output logic [15:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      scanin = din[i];
      shift_dr = 1;
      dout[i] = scanout;
      cyc();
    end
    shift_dr = 0;
    scanin = 0;
  endtask

  task automatic upd();
    update_dr = 1;
    cyc();
    update_dr = 0;
  endtask

  initial begin
    #12 reset_ = 1;
    sel = 1;
    #1;
    chk("rst_q", Q, 16'hA5A5);
    chk("rst_len", chain_len, 16);
    chk("rst_err", upd_err, 0);
    chk("rst_so", scanout, 1);

    cap(16'h1234, 4'hF);
    shift(16'hBEEF, 16, so);
    chk("full_so", so, 16'h1234);
    upd();
    chk("full_q", Q, 16'hBEEF);
    chk("full_err", upd_err, 0);

    cap(16'hFFFF, 4'b0101);
    chk("byp_len", chain_len, 10);
    shift(16'h0000, 10, so);
    chk("byp_so", so, 16'h01EF);
    upd();
    chk("byp_q", Q, 16'hB0E0);

    cap(16'h0000, 4'hF);
    chk("short_len", chain_len, 16);
    shift(16'hFFFF, 15, so);
    upd();
    chk("short_err", upd_err, LC);
    chk("short_q", Q, LC ? 16'hB0E0 : 16'hFFFE);
    cyc();
    chk("short_err_end", upd_err, 0);

    D = 16'h0002;
    capture_dr = 1;
    shift_dr = 1;
    cyc();
    capture_dr = 0;
    shift_dr = 0;
    chk("pri_so", scanout, 0);
    shift(16'h5A5A, 16, so);
    chk("pri_scan", so, 16'h0002);
    upd();
    chk("pri_q", Q, 16'h5A5A);
    chk("pri_err", upd_err, 0);

    sel = 0;
    D = 16'hFFFF;
    scanin = 1;
    capture_dr = 1;
    cyc();
    capture_dr = 0;
    shift_dr = 1;
    cyc();
    shift_dr = 0;
    update_dr = 1;
    cyc();
    update_dr = 0;
    scanin = 0;
    chk("nosel_so", scanout, 0);
    chk("nosel_q", Q, 16'h5A5A);
    chk("nosel_err", upd_err, 0);
    sel = 1;
    shift(16'h0000, 16, so);
    chk("nosel_sr", so, 16'h5A5A);

    cap(16'h1111, 4'b0011);
    chk("mid_len_pre", chain_len, 10);
    shift(16'h0000, 7, so);
    #2 reset_ = 0;
    #1;
    chk("mid_q", Q, 16'hA5A5);
    chk("mid_len", chain_len, 16);
    chk("mid_so", scanout, 1);
    #3 reset_ = 1;
    cyc();
    upd();
    chk("mid_upd_err", upd_err, LC);
    chk("mid_upd_q", Q, 16'hA5A5);
    cyc();
    chk("mid_err_end", upd_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sa_jtag_seg_dr.md
Name: sa_jtag_seg_dr

Overview:
- Parametrised next-generation JTAG data register for SA test/debug access.
- Splits a W-bit register into NUM_SEG equal segments. Each segment either joins the scan chain or is replaced by a 1-bit bypass flop.
- Adds full capture/shift/update sequencing with a shadow (update) stage, so Q changes only on update, never during shift.
- Sits behind the TAP controller; one instance per DR, Q drives SA config/debug fields.

Parameters:
- JTAG_REG_WIDTH, 16, total register width W; must be a multiple of NUM_SEG.
- NUM_SEG, 4, number of selectable segments; SEG_W = W/NUM_SEG.
- RESET_VALUE, all 0 ([W-1:0]), reset value of shift register and shadow Q.

Ports:
- clk  input  1  TCK-domain clock.
- reset_  input  1  asynchronous, active-low reset.
- sel  input  1  this DR selected by the TAP instruction; all ops ignored when 0.
- capture_dr  input  1  capture strobe.
- shift_dr  input  1  shift strobe.
- update_dr  input  1  update strobe.
- seg_en  input  NUM_SEG  segment enable mask; sampled only on capture.
- D  input  W  parallel capture data.
- scanin  input  1  serial in (TDI side).
- scanout  output  1  serial out (TDO side).
- Q  output  W  shadow register output.
- chain_len  output  clog2(W+1)  current chain length L for the latched mask.
- upd_err  output  1  one-cycle pulse: update rejected.

Behaviour:
- State: shift reg SR[W-1:0]; per-segment bypass flop BP[s]; seg_en_q[NUM_SEG-1:0]; shift counter CNT (saturating at 2^width-1); shadow Q.
- Reset (async, reset_=0):
  - SR=RESET_VALUE, Q=RESET_VALUE.
  - BP=0, seg_en_q=all 1s, CNT=0, upd_err=0.
- sel=0: no state changes except upd_err→0; scanout=0.
- Strobe priority with sel=1: capture_dr > shift_dr > update_dr. Only the highest active strobe acts in a cycle.
- Capture:
  - SR<=D, BP<=0, seg_en_q<=seg_en, CNT<=0.
  - seg_en changes at any other time are ignored.
- Shift (one bit per cycle):
  - Chain order, scanin → segment NUM_SEG-1 → … → segment 0 → scanout.
  - Within an enabled segment, bits shift from MSB toward LSB.
  - A disabled segment is a single BP flop.
  - scanout = LSB of segment 0 (SR[0]) if seg_en_q[0]=1, else BP[0]. It is combinational from flops and valid in the same cycle.
  - CNT<=CNT+1, saturating.
- chain_len L = sum over s of (seg_en_q[s] ? SEG_W : 1). Registered with seg_en_q.
- Update:
  - Accepted: Q segments with seg_en_q=1 <= corresponding SR segments; disabled segments keep Q. Visible the cycle after the update_dr edge.
  - Rejected (see optional feature): Q unchanged, upd_err=1 for exactly one cycle.
- Update with no preceding capture since reset: uses the reset mask (all enabled).
- Reset asserted mid-shift: all state returns to reset values immediately; the next update needs a new capture.

Optional Feature:
- Macro SA_JTAG_LEN_CHECK_EN.
- Defined:
  - Update is accepted only if CNT == L; otherwise rejected with an upd_err pulse.
  - Catches short/over-long scans.
- Undefined:
  - Update is always accepted.
  - CNT is removed; upd_err is tied 0.
  - chain_len is still driven.

Decomposition:
- Package sa_jtag_pkg:
  - count-width function clog2.
  - chain-length function f(mask, SEG_W, NUM_SEG).
  - strobe-priority encoding localparams (OP_NONE/CAP/SHF/UPD).
- Sub-module sa_jtag_dr_seg: one segment of SEG_W flops plus bypass flop, enable mux, shadow slice.
- Top level: NUM_SEG instances chained via generate, plus counter and length check.

Test Plan:
- Reset:
  - Stimulus: W=16, NUM_SEG=4, RESET_VALUE=16'hA5A5; reset_ low then high.
  - Response: Q=16'hA5A5, chain_len=16, upd_err=0, scanout=1 with sel=1 (SR[0]=1).
- Full-chain round trip:
  - Stimulus: capture D=16'h1234, shift 16 bits of 16'hBEEF, update.
  - Response: scanout bits = 16'h1234 LSB-first; Q=16'hBEEF one cycle after update.
- Bypass:
  - Stimulus: seg_en=4'b0101 at capture, D=16'hFFFF.
  - Response: chain_len=10.
  - Stimulus: shift 10 bits.
  - Response: scanout = 1,1,1,1,0,1,1,1,1,0 (seg0 ×4, BP1, seg2 ×4, BP3).
  - Stimulus: update.
  - Response: Q[7:4] and Q[15:12] unchanged.
- Length check (SA_JTAG_LEN_CHECK_EN):
  - Stimulus: all segments enabled, shift 15 bits, update.
  - Response: upd_err single-cycle pulse, Q unchanged.
  - Stimulus: same sequence with macro undefined.
  - Response: Q updates, upd_err stays 0.
- Priority/sel:
  - Stimulus: capture_dr and shift_dr high together.
  - Response: capture only, CNT=0.
  - Stimulus: strobes toggled with sel=0.
  - Response: Q, SR unchanged; scanout=0.
- Reset mid-shift:
  - Stimulus: reset_ low after 7 shifts.
  - Response: Q=RESET_VALUE immediately.
  - Stimulus: update with no new capture.
  - Response: rejected with upd_err (check enabled), since CNT=0 ≠ 16.
